// File: rtl/arbitro_pkg.sv
// Shared constants and index helpers for the three-way arbiter.
package arbitro_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] IDX_NONE = 2'd0;
  localparam logic [1:0] IDX_E1   = 2'd1;
  localparam logic [1:0] IDX_E2   = 2'd2;
  localparam logic [1:0] IDX_E3   = 2'd3;

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    case (idx)
      IDX_E1:  return 3'b001;
      IDX_E2:  return 3'b010;
      IDX_E3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    case (oh)
      3'b001:  return IDX_E1;
      3'b010:  return IDX_E2;
      3'b100:  return IDX_E3;
      default: return IDX_NONE;
    endcase
  endfunction

  // Walk upwards through 1..3, wrapping 3 -> 1.
  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx == IDX_E3) ? IDX_E1 : 2'(idx + 2'd1);
  endfunction

  // Walk downwards through 3..1, wrapping 1 -> 3.
  function automatic logic [1:0] idx_prev(input logic [1:0] idx);
    return (idx == IDX_E1 || idx == IDX_NONE) ? IDX_E3 : 2'(idx - 2'd1);
  endfunction

endpackage

// File: rtl/arb_sel3.sv
// Combinational priority selector over three requesters, skipping one index.
// ARB_FIXED_PRIO_EN: scan downwards from start (fixed e3 > e2 > e1 when start = 3).
module arb_sel3
  import arbitro_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] start,
  input  logic [1:0] excl,
  output logic       found,
  output logic [1:0] sel
);

  logic [1:0] cand [3];

`ifdef ARB_FIXED_PRIO_EN
  assign cand[0] = start;
  assign cand[1] = idx_prev(cand[0]);
  assign cand[2] = idx_prev(cand[1]);
`else
  assign cand[0] = start;
  assign cand[1] = idx_next(cand[0]);
  assign cand[2] = idx_next(cand[1]);
`endif

  // Scan back to front so the earliest candidate in the order wins.
  always_comb begin
    found = 1'b0;
    sel   = IDX_NONE;
    for (int k = 2; k >= 0; k--) begin
      if ((cand[k] != excl) && (|(req & idx_to_onehot(cand[k])))) begin
        found = 1'b1;
        sel   = cand[k];
      end
    end
  end

endmodule

// File: rtl/arbitro_rr3.sv
// Three-requester round-robin arbiter with anti-starvation hold timer.
// ARB_FIXED_PRIO_EN: fixed e3 > e2 > e1 priority, no last-owner register.
module arbitro_rr3
  import arbitro_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic             TIMER_EN  = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [0:0]       state, state_nx;
  logic [1:0]       idx_nx;
  logic [2:0]       gnt_nx;
  logic             valid_nx;
  logic [CNT_W-1:0] hold_cnt, cnt_nx;
  logic [1:0]       sel_start, sel_excl, sel_idx;
  logic             sel_found;
  logic             owner_req;

`ifdef ARB_FIXED_PRIO_EN
  assign sel_start = IDX_E3;
`else
  logic [1:0] last;

  assign sel_start = idx_next(last);

  // Remember the most recent owner; it survives a return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDX_E3;
    end else if (idx_nx != IDX_NONE) begin
      last <= idx_nx;
    end
  end
`endif

  assign sel_excl  = (state == ST_GRANT) ? gnt_idx : IDX_NONE;
  assign owner_req = |(req & gnt);

  arb_sel3 u_sel (
    .req   (req),
    .start (sel_start),
    .excl  (sel_excl),
    .found (sel_found),
    .sel   (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= 3'b000;
      gnt_idx   <= IDX_NONE;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      hold_cnt  <= cnt_nx;
    end
  end

  // Next owner: release first, then timer expiry, else keep counting.
  always_comb begin
    state_nx = state;
    idx_nx   = gnt_idx;
    cnt_nx   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          state_nx = ST_GRANT;
          idx_nx   = sel_idx;
          cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          cnt_nx = '0;
          if (sel_found) begin
            idx_nx = sel_idx;
          end else begin
            state_nx = ST_IDLE;
            idx_nx   = IDX_NONE;
          end
        end else if (TIMER_EN && (hold_cnt == HOLD_LAST)) begin
          cnt_nx = '0;
          if (sel_found) begin
            idx_nx = sel_idx;
          end
        end else if (TIMER_EN) begin
          cnt_nx = CNT_W'(hold_cnt + CNT_W'(1));
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = IDX_NONE;
        cnt_nx   = '0;
      end
    endcase
    gnt_nx   = idx_to_onehot(idx_nx);
    valid_nx = (idx_nx != IDX_NONE);
  end

endmodule

// File: tb/tb_arbitro_rr3.sv
// Directed scoreboard bench for arbitro_rr3 with HOLD_MAX = 4.
module tb_arbitro_rr3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  logic [1:0] exp_q [$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  arbitro_rr3 #(
    .HOLD_MAX (4),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  task automatic check(input string tag);
    logic [1:0] e;
    logic [2:0] eg;
    logic       ev;
    e  = exp_q.pop_front();
    eg = (e == 2'd0) ? 3'b000 : 3'(3'b001 << (e - 2'd1));
    ev = (e != 2'd0);
    n_total++;
    assert (gnt === eg) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s gnt got %b want %b", tag, gnt, eg);
    end
    n_total++;
    assert (gnt_idx === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s gnt_idx got %b want %b", tag, gnt_idx, e);
    end
    n_total++;
    assert (gnt_valid === ev) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s gnt_valid got %b want %b", tag, gnt_valid, ev);
    end
  endtask

  // Drive one cycle of inputs, queue the expected owner, compare after the edge.
  task automatic step(input logic r, input logic [2:0] q, input logic [1:0] e, input string tag);
    rst = r;
    req = q;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    step(1'b1, 3'b000, 2'd0, "reset0");
    step(1'b1, 3'b111, 2'd0, "reset_req_ignored");

`ifdef ARB_FIXED_PRIO_EN
    step(1'b0, 3'b111, 2'd3, "fixed_all");
    step(1'b0, 3'b011, 2'd2, "fixed_release");
    step(1'b0, 3'b000, 2'd0, "fixed_idle");
`else
    for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 2'd0, "idle");

    step(1'b0, 3'b001, 2'd1, "single_e1");
    step(1'b0, 3'b000, 2'd0, "single_drop");

    // Fresh reset so the rotation starts at e1.
    step(1'b1, 3'b000, 2'd0, "rr_reset");
    step(1'b0, 3'b111, 2'd1, "rr_first");
    step(1'b0, 3'b110, 2'd2, "rr_handoff_e2");
    step(1'b0, 3'b101, 2'd3, "rr_handoff_e3");
    step(1'b0, 3'b011, 2'd1, "rr_wrap_e1");
    step(1'b0, 3'b110, 2'd2, "rr_again_e2");
    step(1'b0, 3'b000, 2'd0, "rr_idle");

    // last = e2, so e3 is scanned first, then e1 wins.
    for (int i = 0; i < 13; i++)
      step(1'b0, 3'b011, 2'((i < 4) ? 1 : (i < 8) ? 2 : (i < 12) ? 1 : 2), "hold_rotate");

    // Owner e2 alone: non-owner drop is harmless, timer expiry keeps the grant.
    for (int i = 0; i < 6; i++) step(1'b0, 3'b010, 2'd2, "hold_keep");
    step(1'b0, 3'b000, 2'd0, "hold_idle");

    for (int i = 0; i < 20; i++) step(1'b0, 3'b100, 2'd3, "solo_e3");
    step(1'b1, 3'b111, 2'd0, "mid_reset");
    step(1'b0, 3'b111, 2'd1, "post_reset_e1");

    step(1'b0, 3'b001, 2'd1, "nonowner_drop");
    step(1'b0, 3'b100, 2'd3, "late_req_handoff");
    step(1'b0, 3'b000, 2'd0, "final_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arbitro_rr3.md
Name: arbitro_rr3

Overview:
- Round-robin arbiter that shares one resource between three requesters.
- Requesters use the same naming and bit order as the 3-input encoder: bit0 is e1, bit1 is e2, bit2 is e3.
- Outputs a one-hot grant plus a 2-bit encoded owner index (1..3; 0 = none), so it can drive encoder-style s1/s0 selects directly.
- Includes a hold timer so that no single requester can starve the others.

Parameters:
- HOLD_MAX, default 8: maximum consecutive cycles one owner keeps the grant while others are pending. 0 disables the timer.
- CNT_W, default 4: width of the hold counter. Requires 2^CNT_W >= HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  3  request vector. Bit0 = e1, bit1 = e2, bit2 = e3. Level-held while the resource is wanted.
- gnt  output  3  one-hot grant, registered.
- gnt_idx  output  2  encoded owner (01 = e1, 10 = e2, 11 = e3, 00 = none), registered.
- gnt_valid  output  1  equals |gnt, registered.

Behaviour:
- All outputs are registered. Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: gnt = 000, gnt_idx = 00, gnt_valid = 0, state = IDLE, last = 3 (so the first search starts at index 1), hold_cnt = 0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 000 at edge k: gnt/gnt_idx reflect the selected requester after edge k (latency 1 cycle). Go to GRANT, last <= selected, hold_cnt <= 0.
  - Otherwise stay in IDLE.
- Selection: scan indices starting at last+1, wrapping 3 -> 1; the first pending index wins. Indices are 2-bit, and 0 is never a requester.
- GRANT, evaluated at each edge in this priority order:
  1. Owner's req is low (release):
     - If other requests are pending, hand off in the same edge to the next pending requester after the owner. No idle bubble.
     - Otherwise go to IDLE with gnt = 000.
  2. HOLD_MAX != 0, hold_cnt == HOLD_MAX-1, and another requester is pending (preempt): rotate to the next pending requester after the owner; hold_cnt <= 0.
  3. HOLD_MAX != 0, hold_cnt == HOLD_MAX-1, and no other requester is pending: the owner keeps the grant; hold_cnt <= 0.
  4. Otherwise: hold_cnt <= hold_cnt + 1. The counter saturates and never wraps past HOLD_MAX-1.
- Every new grant sets last <= new owner and hold_cnt <= 0.
- A new request arriving in the same edge as the owner's release is eligible for the handoff.
- gnt is never more than one-hot. gnt_idx is always consistent with gnt.
- rst asserted in any state, including mid-grant, forces reset values at that edge. Requests are ignored while rst = 1.
- Deasserting a non-owner request has no effect on the current grant.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - Selection ignores last and uses fixed priority e3 > e2 > e1, matching the encoder's highest-input-wins order.
  - Timer preemption selects the highest pending index other than the owner.
  - The last register is not implemented.
- Undefined: round-robin as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Package arbitro_pkg:
  - state constants ST_IDLE and ST_GRANT.
  - index constants IDX_NONE = 2'd0, IDX_E1 = 2'd1, IDX_E2 = 2'd2, IDX_E3 = 2'd3.
  - one-hot <-> index conversion functions.
- Sub-module arb_sel3: combinational rotating priority selector.
  - Inputs: req[2:0], start index, exclude index.
  - Outputs: found flag, selected index.
  - Instantiated once and shared by the IDLE, release and preempt paths.

Test Plan:
- Reset held 2 cycles, then req = 000 for 5 cycles -> gnt = 000, gnt_idx = 00, gnt_valid = 0 throughout.
- req = 001 at edge 1 -> gnt = 001, gnt_idx = 01 after edge 1. Drop req -> gnt = 000 after the next edge.
- req = 111, each owner drops its bit 1 cycle after being granted and re-raises it 1 cycle later -> gnt_idx sequence 01, 10, 11, 01 with no 00 bubble between owners.
- HOLD_MAX = 4, req = 011 held constantly -> gnt = 001 for 4 cycles, 010 for 4 cycles, 001 for 4 cycles, repeating.
- HOLD_MAX = 4, req = 100 held for 20 cycles -> gnt = 100 uninterrupted. Then rst pulses 1 cycle mid-grant with req = 111 -> gnt = 000 after the rst edge, then gnt_idx = 01 on the next edge.
- ARB_FIXED_PRIO_EN defined, req = 111 -> gnt_idx = 11. Drop bit2 -> gnt_idx = 10 in the same edge as the release.
